// File: rtl/zap_tlb_assoc.sv
// Fully associative unified TLB for section/large/small/tiny translations.
// Round-robin victim pointer, in-place refills, multi-cycle invalidate-by-VA sweep.

module zap_tlb_assoc #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_hold,
  input  logic             i_mmu_en,
  input  logic             i_lkp_valid,
  input  logic [31:0]      i_lkp_va,
  output logic             o_lkp_done,
  output logic             o_lkp_hit,
  output logic [31:0]      o_lkp_pa,
  output logic [1:0]       o_lkp_ap,
  output logic [3:0]       o_lkp_dom,
  output logic [1:0]       o_lkp_cb,
  output logic [1:0]       o_lkp_size,
  input  logic             i_fill_valid,
  output logic             o_fill_ready,
  input  logic [31:0]      i_fill_va,
  input  logic [31:0]      i_fill_pa,
  input  logic [1:0]       i_fill_size,
  input  logic [1:0]       i_fill_ap,
  input  logic [3:0]       i_fill_dom,
  input  logic [1:0]       i_fill_cb,
  input  logic             i_inv_all,
  input  logic             i_inv_va_valid,
  input  logic [31:0]      i_inv_va,
  output logic             o_busy,
  output logic             o_inv_done,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);
  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  typedef struct packed {
    logic        vld;
    logic [1:0]  size;
    logic [21:0] tag;
    logic [21:0] base;
    logic [1:0]  ap;
    logic [3:0]  dom;
    logic [1:0]  cb;
  } ent_t;

  // Tag bits [31:10] that take part in the compare for each page size.
  function automatic logic [21:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 22'h3FFC00;
      2'b01:   size_mask = 22'h3FFFC0;
      2'b10:   size_mask = 22'h3FFFFC;
      default: size_mask = 22'h3FFFFF;
    endcase
  endfunction

  ent_t             r_ent [ENTRIES];
  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_vptr;
  logic [21:0]      r_inv_tag;
  logic             r_busy;
  logic             r_inv_done;
  logic             r_lkp_done;
  logic             r_lkp_hit;
  logic [31:0]      r_lkp_pa;
  logic [1:0]       r_lkp_ap;
  logic [3:0]       r_lkp_dom;
  logic [1:0]       r_lkp_cb;
  logic [1:0]       r_lkp_size;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [ENTRIES-1:0]       w_lkp_m;
  logic [ENTRIES-1:0]       w_fill_m;
  logic [ENTRIES-1:0]       w_inv_m;
  logic [ENTRIES-1:0][21:0] w_mask;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign w_mask[g]   = size_mask(r_ent[g].size);
    assign w_lkp_m[g]  = r_ent[g].vld && (((r_ent[g].tag ^ i_lkp_va[31:10]) & w_mask[g]) == '0);
    assign w_fill_m[g] = r_ent[g].vld && (r_ent[g].size == i_fill_size) &&
                         (((r_ent[g].tag ^ i_fill_va[31:10]) & w_mask[g]) == '0);
    assign w_inv_m[g]  = r_ent[g].vld && (((r_ent[g].tag ^ r_inv_tag) & w_mask[g]) == '0);
  end

  // Lowest index wins for lookup hits, same-size refills and free slots.
  logic          w_lkp_any, w_fill_any, w_free_any;
  logic [IW-1:0] w_lkp_idx, w_fill_hit_idx, w_free_idx;
  always_comb begin
    w_lkp_any      = 1'b0;
    w_fill_any     = 1'b0;
    w_free_any     = 1'b0;
    w_lkp_idx      = '0;
    w_fill_hit_idx = '0;
    w_free_idx     = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (w_lkp_m[i])     begin w_lkp_any  = 1'b1; w_lkp_idx      = IW'(i); end
      if (w_fill_m[i])    begin w_fill_any = 1'b1; w_fill_hit_idx = IW'(i); end
      if (!r_ent[i].vld)  begin w_free_any = 1'b1; w_free_idx     = IW'(i); end
    end
  end

  ent_t        w_sel;
  logic [21:0] w_sel_mask;
  logic [31:0] w_pa;
  assign w_sel      = r_ent[w_lkp_idx];
  assign w_sel_mask = w_mask[w_lkp_idx];
  assign w_pa       = {(w_sel.base & w_sel_mask) | (i_lkp_va[31:10] & ~w_sel_mask), i_lkp_va[9:0]};

  logic          w_inv_all, w_fill_fire, w_sweep_go, w_lkp_fire;
  logic [IW-1:0] w_fill_idx;
  ent_t          w_new;
  assign w_inv_all   = i_inv_all | ~i_mmu_en;
  assign w_fill_fire = i_fill_valid & ~r_busy & ~i_hold & ~i_inv_all & i_mmu_en;
  assign w_sweep_go  = i_inv_va_valid & ~r_busy & ~w_inv_all & ~i_hold;
  assign w_lkp_fire  = i_lkp_valid & ~r_busy & ~i_hold & ~w_fill_fire & ~w_sweep_go;
  assign w_fill_idx  = w_fill_any ? w_fill_hit_idx : (w_free_any ? w_free_idx : r_vptr);

  always_comb begin
    w_new      = '0;
    w_new.vld  = 1'b1;
    w_new.size = i_fill_size;
    w_new.tag  = i_fill_va[31:10];
    w_new.base = i_fill_pa[31:10];
    w_new.ap   = i_fill_ap;
    w_new.dom  = i_fill_dom;
    w_new.cb   = i_fill_cb;
  end

  logic w_unused;
  assign w_unused = ^{i_fill_va[9:0], i_fill_pa[9:0], i_inv_va[9:0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_vptr     <= '0;
      r_inv_tag  <= '0;
      r_busy     <= 1'b0;
      r_inv_done <= 1'b0;
      r_lkp_done <= 1'b0;
      r_lkp_hit  <= 1'b0;
      r_lkp_pa   <= '0;
      r_lkp_ap   <= '0;
      r_lkp_dom  <= '0;
      r_lkp_cb   <= '0;
      r_lkp_size <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (!i_hold) begin
      if (w_inv_all) begin
        for (int i = 0; i < ENTRIES; i++) r_ent[i].vld <= 1'b0;
      end else if (r_state == S_SWEEP && w_inv_m[r_idx]) begin
        r_ent[r_idx].vld <= 1'b0;
      end

      // Fills never coincide with a sweep or an invalidate-all (fill is gated off).
      if (w_fill_fire) begin
        r_ent[w_fill_idx] <= w_new;
        if (!w_fill_any && (w_fill_idx == r_vptr)) r_vptr <= r_vptr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_sweep_go) begin
            r_state   <= S_SWEEP;
            r_idx     <= '0;
            r_inv_tag <= i_inv_va[31:10];
            r_busy    <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (w_inv_all || r_idx == IW'(ENTRIES-1)) begin
            r_state    <= S_DONE;
            r_inv_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_inv_done <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_inv_done <= 1'b0;
        end
      endcase

      r_lkp_done <= w_lkp_fire;
      if (w_lkp_fire) begin
        r_lkp_hit  <= w_lkp_any;
        r_lkp_pa   <= w_lkp_any ? w_pa       : '0;
        r_lkp_ap   <= w_lkp_any ? w_sel.ap   : '0;
        r_lkp_dom  <= w_lkp_any ? w_sel.dom  : '0;
        r_lkp_cb   <= w_lkp_any ? w_sel.cb   : '0;
        r_lkp_size <= w_lkp_any ? w_sel.size : '0;
        if (w_lkp_any) begin
          if (~&r_hit_cnt) r_hit_cnt <= r_hit_cnt + 1'b1;
        end else begin
          if (~&r_miss_cnt) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end
    end
  end

  assign o_lkp_done   = r_lkp_done;
  assign o_lkp_hit    = r_lkp_hit;
  assign o_lkp_pa     = r_lkp_pa;
  assign o_lkp_ap     = r_lkp_ap;
  assign o_lkp_dom    = r_lkp_dom;
  assign o_lkp_cb     = r_lkp_cb;
  assign o_lkp_size   = r_lkp_size;
  assign o_fill_ready = w_fill_fire;
  assign o_busy       = r_busy;
  assign o_inv_done   = r_inv_done;
  assign o_hit_cnt    = r_hit_cnt;
  assign o_miss_cnt   = r_miss_cnt;

endmodule
